// File: rtl/io_word_master.sv
// io_word_master: serializes word-level core requests (1..DATA_W bits at
// contiguous bit addresses) into one bit-wide IO access per cycle and packs
// read bits back into a word. All outputs decode from state and registers.
module io_word_master #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 24,
    parameter int WR_LIMIT = 35,
    parameter int RD_LIMIT = 75
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              io_en,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0]      MAX_LEN  = 5'(DATA_W);
    localparam logic [ADDR_W:0] WR_END   = (ADDR_W+1)'(WR_LIMIT);
    localparam logic [ADDR_W:0] RD_END   = (ADDR_W+1)'(RD_LIMIT);

    state_t              state;
    state_t              next_state;

    // Request fields latched at acceptance; the requester may change its
    // inputs afterwards.
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [4:0]          len;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic [4:0]          cnt;
    logic                err;

    logic                accept;
    logic                legal;
    logic [ADDR_W:0]     end_addr;
    logic                last_bit;

    // Only bit 0 of the IO read bus carries data.
    logic                unused_rdata;
    assign unused_rdata = ^io_rdata[DATA_W-1:1];

    // End address is one bit wider than the address so a request that runs
    // past the top of the address space is rejected instead of wrapping.
    assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(req_len) - 1'b1;
    assign legal    = (req_len != 5'd0) && (req_len <= MAX_LEN) &&
                      (req_write ? (end_addr <= WR_END) : (end_addr <= RD_END));
    assign accept   = (state == IDLE) && req_valid;
    assign last_bit = (cnt == len - 5'd1);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and output decode from state and counter.
    // NOTE: every output gets a default first, so no path leaves a signal
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        io_en      = 1'b0;
        io_addr    = '0;
        io_wdata   = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    next_state = legal ? XFER : RESP;
                end
            end
            XFER: begin
                io_addr = addr + ADDR_W'(cnt);
                if (wr) begin
                    io_en    = 1'b1;
                    io_wdata = {{(DATA_W-1){1'b0}}, wdata[cnt]};
                end
                if (last_bit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err;
                resp_rdata = rdata;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latch, bit counter and read-data gather.
    // NOTE: these registers are reset too, so an abort by reset leaves no
    // partial read data or stale error flag behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr    <= 1'b0;
            addr  <= '0;
            len   <= '0;
            wdata <= '0;
            rdata <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            wr    <= req_write;
            addr  <= req_addr;
            len   <= req_len;
            wdata <= req_wdata;
            rdata <= '0;
            cnt   <= '0;
            err   <= ~legal;
        end else if (state == XFER) begin
            cnt <= cnt + 5'd1;
            if (!wr) begin
                rdata[cnt] <= io_rdata[0];
            end
        end
    end

endmodule

// File: tb/tb_io_word_master.sv
// Bench for io_word_master: table of word requests against a bit-addressed
// IO memory model, plus back-to-back and reset-abort sequences.
module tb_io_word_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [4:0]  req_len;
    logic [23:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [23:0] resp_rdata;
    logic        busy;
    logic        io_en;
    logic [7:0]  io_addr;
    logic [23:0] io_wdata;
    logic [23:0] io_rdata;

    logic        mem [256];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [4:0]  len;
        logic [23:0] wdata;
        logic        exp_err;
        logic [23:0] exp_rdata;
    } vec_t;

    vec_t vecs[17];

    io_word_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .io_en      (io_en),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata)
    );

    always #5 clk = ~clk;

    // IO memory model: combinational read, write on the strobe.
    assign io_rdata = {{23{1'b0}}, mem[io_addr]};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 1'b0;
        mem[72] = 1'b1;
        mem[73] = 1'b0;
        mem[74] = 1'b1;
        mem[75] = 1'b1;
        forever begin
            @(posedge clk);
            if (io_en) mem[io_addr] <= io_wdata[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req_ready"},  32'(req_ready),  32'd1);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " resp_err"},   32'(resp_err),   32'd0);
        check({tag, " resp_rdata"}, 32'(resp_rdata), 32'd0);
        check({tag, " io_en"},      32'(io_en),      32'd0);
        check({tag, " io_addr"},    32'(io_addr),    32'd0);
        check({tag, " io_wdata"},   32'(io_wdata),   32'd0);
    endtask

    // Issue one request and check every cycle until IDLE returns.
    task automatic run_req(input int idx, input vec_t v);
        int          lat;
        logic        legal;
        logic        in_xfer;
        logic [7:0]  exp_addr;
        logic        exp_bit;
        string       tag;
        legal = !v.exp_err;
        lat   = legal ? int'(v.len) + 1 : 1;
        @(negedge clk);
        check($sformatf("v%0d ready_before", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_len   = v.len;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        // Scramble inputs to prove the request was latched.
        req_valid = 1'b0;
        req_write = ~v.write;
        req_addr  = ~v.addr;
        req_len   = 5'd3;
        req_wdata = ~v.wdata;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            tag      = $sformatf("v%0d c%0d", idx, c);
            in_xfer  = legal && (c <= int'(v.len));
            exp_addr = in_xfer ? v.addr + 8'(c - 1) : 8'd0;
            exp_bit  = (in_xfer && v.write) ? v.wdata[c - 1] : 1'b0;
            check({tag, " io_en"},      32'(io_en),      32'(in_xfer && v.write));
            check({tag, " io_addr"},    32'(io_addr),    32'(exp_addr));
            check({tag, " io_wdata"},   32'(io_wdata),   32'(exp_bit));
            check({tag, " resp_valid"}, 32'(resp_valid), 32'(c == lat));
            check({tag, " busy"},       32'(busy),       32'(c <= lat));
            check({tag, " req_ready"},  32'(req_ready),  32'(c == lat + 1));
            if (c == lat) begin
                check({tag, " resp_err"},   32'(resp_err),   32'(v.exp_err));
                check({tag, " resp_rdata"}, 32'(resp_rdata), 32'(v.exp_rdata));
            end
        end
    endtask

    initial begin
        int low;
        int nresp;

        vecs[0]  = '{1'b1, 8'd4,   5'd8,  24'h0000A5, 1'b0, 24'h000000};
        vecs[1]  = '{1'b0, 8'd72,  5'd4,  24'hFFFFFF, 1'b0, 24'h00000D};
        vecs[2]  = '{1'b0, 8'd4,   5'd8,  24'h000000, 1'b0, 24'h0000A5};
        vecs[3]  = '{1'b1, 8'd30,  5'd8,  24'h0000FF, 1'b1, 24'h000000};
        vecs[4]  = '{1'b0, 8'd70,  5'd7,  24'h000000, 1'b1, 24'h000000};
        vecs[5]  = '{1'b1, 8'd0,   5'd0,  24'h000001, 1'b1, 24'h000000};
        vecs[6]  = '{1'b0, 8'd0,   5'd25, 24'h000000, 1'b1, 24'h000000};
        vecs[7]  = '{1'b1, 8'd12,  5'd24, 24'h5AC30F, 1'b0, 24'h000000};
        vecs[8]  = '{1'b0, 8'd12,  5'd24, 24'h000000, 1'b0, 24'h5AC30F};
        vecs[9]  = '{1'b0, 8'd75,  5'd1,  24'h000000, 1'b0, 24'h000001};
        vecs[10] = '{1'b1, 8'd35,  5'd1,  24'h000001, 1'b0, 24'h000000};
        vecs[11] = '{1'b1, 8'd36,  5'd1,  24'h000001, 1'b1, 24'h000000};
        vecs[12] = '{1'b0, 8'd34,  5'd2,  24'h000000, 1'b0, 24'h000003};
        vecs[13] = '{1'b0, 8'd0,   5'd1,  24'hFFFFFF, 1'b0, 24'h000000};
        vecs[14] = '{1'b0, 8'd255, 5'd1,  24'h000000, 1'b1, 24'h000000};
        vecs[15] = '{1'b1, 8'd250, 5'd24, 24'hFFFFFF, 1'b1, 24'h000000};
        vecs[16] = '{1'b0, 8'd76,  5'd1,  24'h000000, 1'b1, 24'h000000};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_req(i, vecs[i]);

        // Back-to-back: req_valid held high; second request waits for IDLE.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'd0;
        req_len   = 5'd3;
        req_wdata = 24'h000005;
        @(posedge clk);
        low = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 5 && !req_ready) low++;
            if (c == 4) begin
                check("b2b resp_valid_a", 32'(resp_valid), 32'd1);
                check("b2b ready_in_resp", 32'(req_ready), 32'd0);
            end
            if (c == 5) begin
                check("b2b ready_idle", 32'(req_ready), 32'd1);
                check("b2b io_en_idle", 32'(io_en), 32'd0);
            end
            if (c == 6) begin
                check("b2b io_en_b", 32'(io_en), 32'd1);
                check("b2b io_addr_b", 32'(io_addr), 32'd0);
                check("b2b io_wdata_b", 32'(io_wdata), 32'd1);
                req_valid = 1'b0;
            end
            if (c == 9) check("b2b resp_valid_b", 32'(resp_valid), 32'd1);
            if (c == 10) check("b2b idle_after_b", 32'(busy), 32'd0);
        end
        check("b2b ready_low_cycles", 32'(low), 32'd4);

        // Reset during the 3rd XFER cycle of an 8-bit write.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'd20;
        req_len   = 5'd8;
        req_wdata = 24'h0000FE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_seq c%0d io_en", c), 32'(io_en), 32'd1);
            check($sformatf("rst_seq c%0d io_addr", c), 32'(io_addr), 32'(19 + c));
        end
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        check("rst_no_resp", 32'(nresp), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);
        // Bits 20,21 were written (0,1); bit 22 keeps its prior 0.
        run_req(100, '{1'b0, 8'd20, 5'd3, 24'h000000, 1'b0, 24'h000002});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
